// File: rtl/sort_frame_controller_if.sv
// Valid/ready element streams into and out of the sort frame controller.
// The slave modport is the controller's view; master is the upstream/downstream view.
interface sort_frame_controller_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/sort_frame_controller.sv
// Frame sequencer for the comparator-chain sorter: loads N elements, flushes the
// chain with N all-ones pads, captures N results at a fixed latency and replays them.
module sort_frame_controller #(
  parameter int DW       = 8,
  parameter int N        = 4,
  parameter int SORT_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sort_frame_controller_if.slave s,
  output logic [DW-1:0]          srt_data,
  output logic                   srt_en,
  output logic                   srt_start,
  output logic                   srt_pad,
  input  logic [DW-1:0]          srt_res,
  output logic                   busy
);
  localparam int CW = $clog2(N + SORT_LAT + 1);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_EL  = CW'(N - 1);
  localparam logic [CW-1:0] PAD_CNT  = CW'(N);
  localparam logic [CW-1:0] CAP_LAST = CW'(SORT_LAT + N);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          out_last_reg;
  logic [DW-1:0] out_data_reg;
  logic [DW-1:0] srt_data_reg;
  logic          srt_en_reg;
  logic          srt_start_reg;
  logic          srt_pad_reg;
  logic          busy_reg;
  logic [DW-1:0] buf_q [N];
  logic          in_xfer;
  logic          out_xfer;
  logic [CW-1:0] rd_next;
  logic [AW-1:0] rd_idx;

  assign in_xfer = s.in_valid & in_ready_reg;
  assign out_xfer = out_valid_reg & s.out_ready;
  assign rd_next = cnt_reg + 1'b1;
  assign rd_idx = rd_next[AW-1:0];

  assign s.in_ready  = in_ready_reg;
  assign s.out_valid = out_valid_reg;
  assign s.out_last  = out_last_reg;
  assign s.out_data  = out_data_reg;
  assign srt_data    = srt_data_reg;
  assign srt_en      = srt_en_reg;
  assign srt_start   = srt_start_reg;
  assign srt_pad     = srt_pad_reg;
  assign busy        = busy_reg;

  // In DRAIN the first pad is on srt_data while cnt_reg==1, so result k is
  // presented while cnt_reg == SORT_LAT+1+k.
  for (genvar gi = 0; gi < N; gi++) begin : g_buf
    logic [DW-1:0] cap_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cap_reg <= '0;
      end else if (state_reg == DRAIN && cnt_reg == CW'(SORT_LAT + 1 + gi)) begin
        cap_reg <= srt_res;
      end
    end
    assign buf_q[gi] = cap_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_data_reg  <= '0;
      srt_data_reg  <= '0;
      srt_en_reg    <= 1'b0;
      srt_start_reg <= 1'b0;
      srt_pad_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      srt_en_reg    <= 1'b0;
      srt_start_reg <= 1'b0;
      srt_pad_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (in_xfer) begin
            srt_data_reg  <= s.in_data;
            srt_en_reg    <= 1'b1;
            srt_start_reg <= 1'b1;
            cnt_reg       <= CW'(1);
            state_reg     <= LOAD;
            busy_reg      <= 1'b1;
          end
        end
        LOAD: begin
          if (in_xfer) begin
            srt_data_reg <= s.in_data;
            srt_en_reg   <= 1'b1;
            if (cnt_reg == LAST_EL) begin
              state_reg    <= DRAIN;
              in_ready_reg <= 1'b0;
              cnt_reg      <= '0;
            end else begin
              cnt_reg <= rd_next;
            end
          end
        end
        DRAIN: begin
          cnt_reg <= rd_next;
          if (cnt_reg < PAD_CNT) begin
            srt_en_reg   <= 1'b1;
            srt_pad_reg  <= 1'b1;
            srt_data_reg <= '1;
          end
          // Leave on the edge that captures the last result; buf[0] is long settled.
          if (cnt_reg == CAP_LAST) begin
            state_reg     <= OUT;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b1;
            out_data_reg  <= buf_q[0];
            out_last_reg  <= 1'b0;
          end
        end
        OUT: begin
          if (out_xfer) begin
            if (cnt_reg == LAST_EL) begin
              state_reg     <= IDLE;
              cnt_reg       <= '0;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              out_data_reg  <= '0;
              in_ready_reg  <= 1'b1;
              busy_reg      <= 1'b0;
            end else begin
              cnt_reg      <= rd_next;
              out_data_reg <= buf_q[rd_idx];
              out_last_reg <= (rd_next == LAST_EL);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sort_frame_controller.sv
// Directed bench: two controllers (SORT_LAT 4 and 1) driven by an ascending
// sorter model that presents results only in the expected capture window.
module tb_sort_frame_controller;
  localparam int DW = 8;
  localparam int N  = 4;

  typedef logic [DW-1:0] frame_t [N];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] in_data   [2];
  logic          in_valid  [2];
  logic          out_ready [2];
  logic          in_ready  [2];
  logic [DW-1:0] out_data  [2];
  logic          out_valid [2];
  logic          out_last  [2];
  logic [DW-1:0] srt_data  [2];
  logic          srt_en    [2];
  logic          srt_start [2];
  logic          srt_pad   [2];
  logic [DW-1:0] srt_res   [2];
  logic          busy      [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    sort_frame_controller_if #(.DW(DW)) bus ();
    assign bus.in_data   = in_data[gi];
    assign bus.in_valid  = in_valid[gi];
    assign bus.out_ready = out_ready[gi];
    assign in_ready[gi]  = bus.in_ready;
    assign out_data[gi]  = bus.out_data;
    assign out_valid[gi] = bus.out_valid;
    assign out_last[gi]  = bus.out_last;

    sort_frame_controller #(.DW(DW), .N(N), .SORT_LAT((gi == 0) ? 4 : 1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s         (bus),
      .srt_data  (srt_data[gi]),
      .srt_en    (srt_en[gi]),
      .srt_start (srt_start[gi]),
      .srt_pad   (srt_pad[gi]),
      .srt_res   (srt_res[gi]),
      .busy      (busy[gi])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic frame_t sort_asc(input frame_t f);
    frame_t r;
    logic [DW-1:0] t;
    r = f;
    for (int a = 0; a < N - 1; a++)
      for (int b = 0; b < N - 1 - a; b++)
        if (r[b] > r[b + 1]) begin
          t = r[b];
          r[b] = r[b + 1];
          r[b + 1] = t;
        end
    return r;
  endfunction

  // Sorter model and sorter-side monitors, evaluated mid-cycle.
  frame_t        frame_m  [2];
  frame_t        sorted_m [2];
  int            fill_m   [2];
  int            p0_m     [2];
  int            pad_run  [2];
  int            n_start  [2];
  int            n_pad    [2];
  int            n_gap    [2];
  int            n_badpad [2];
  logic [DW-1:0] start_val[2];
  int            cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (srt_en[i] && !srt_pad[i]) begin
        if (srt_start[i]) begin
          frame_m[i][0] <= srt_data[i];
          fill_m[i]     <= 1;
          n_start[i]    <= n_start[i] + 1;
          start_val[i]  <= srt_data[i];
        end else begin
          if (fill_m[i] < N) frame_m[i][fill_m[i]] <= srt_data[i];
          fill_m[i] <= fill_m[i] + 1;
        end
      end
      if (!srt_en[i] && fill_m[i] > 0 && fill_m[i] < N) n_gap[i] <= n_gap[i] + 1;
      if (srt_pad[i]) begin
        n_pad[i]   <= n_pad[i] + 1;
        pad_run[i] <= pad_run[i] + 1;
        if (!srt_en[i] || srt_data[i] !== {DW{1'b1}}) n_badpad[i] <= n_badpad[i] + 1;
        if (pad_run[i] == 0) begin
          p0_m[i]     <= cyc;
          sorted_m[i] <= sort_asc(frame_m[i]);
        end
      end else begin
        pad_run[i] <= 0;
        if (pad_run[i] != 0 && pad_run[i] != N) n_badpad[i] <= n_badpad[i] + 1;
      end
      if (cyc - p0_m[i] - lat_of(i) >= 0 && cyc - p0_m[i] - lat_of(i) < N)
        srt_res[i] <= sorted_m[i][cyc - p0_m[i] - lat_of(i)];
      else
        srt_res[i] <= 8'hEE;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] in_list [$];
  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int            hold_err;
  int            ready_err;

  // Drives in_list into instance i and collects n_out outputs; optional input
  // gap after item gap_idx and an out_ready stall when stall_val first appears.
  task automatic run_frames(input int i, input int n_out, input int gap_idx, input int gap_len,
                            input logic [DW-1:0] stall_val, input int stall_len, input string tag);
    int acc = 0;
    int gap_rem = 0;
    int stall_rem = 0;
    int cyc_n = 0;
    bit stall_done = 1'b0;
    logic pv_iv = 1'b0, pv_ir = 1'b0, pv_ov = 1'b0, pv_or = 1'b0, pv_ol = 1'b0;
    logic [DW-1:0] pv_od = '0;
    got_d.delete();
    got_l.delete();
    hold_err = 0;
    ready_err = 0;
    while (got_d.size() < n_out && cyc_n < 300) begin
      @(posedge clk);
      #1;
      cyc_n++;
      if (pv_iv && pv_ir) begin
        if (acc == gap_idx) gap_rem = gap_len;
        void'(in_list.pop_front());
        acc++;
      end
      if (pv_ov && pv_or) begin
        got_d.push_back(pv_od);
        got_l.push_back(pv_ol);
      end else if (pv_ov && (!out_valid[i] || out_data[i] !== pv_od || out_last[i] !== pv_ol)) begin
        hold_err++;
      end
      if (in_ready[i] && (acc % N) == 0 && acc > got_d.size()) ready_err++;
      if (gap_rem > 0) begin
        in_valid[i] = 1'b0;
        gap_rem--;
      end else if (in_list.size() > 0) begin
        in_valid[i] = 1'b1;
        in_data[i]  = in_list[0];
      end else begin
        in_valid[i] = 1'b0;
      end
      if (stall_len > 0 && !stall_done && out_valid[i] && out_data[i] === stall_val) begin
        stall_rem = stall_len;
        stall_done = 1'b1;
      end
      if (stall_rem > 0) begin
        out_ready[i] = 1'b0;
        stall_rem--;
      end else begin
        out_ready[i] = 1'b1;
      end
      pv_iv = in_valid[i];
      pv_ir = in_ready[i];
      pv_ov = out_valid[i];
      pv_or = out_ready[i];
      pv_od = out_data[i];
      pv_ol = out_last[i];
    end
    in_valid[i] = 1'b0;
    out_ready[i] = 1'b1;
    check({tag, "_outcount"}, 32'(got_d.size()), 32'(n_out));
    check({tag, "_hold"}, 32'(hold_err), 32'd0);
    check({tag, "_inready"}, 32'(ready_err), 32'd0);
  endtask

  task automatic check_out(input string tag, input int base,
                           input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic [DW-1:0] e3);
    frame_t e;
    e = '{e0, e1, e2, e3};
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_data%0d", tag, k),
            (base + k < got_d.size()) ? 32'(got_d[base + k]) : 32'hDEAD, 32'(e[k]));
      check($sformatf("%s_last%0d", tag, k),
            (base + k < got_l.size()) ? 32'(got_l[base + k]) : 32'hDEAD, 32'(k == N - 1));
    end
  endtask

  int s_start;
  int s_pad;
  int s_gap;

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready[0]), 32'd0);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_last", 32'(out_last[0]), 32'd0);
    check("rst_out_data", 32'(out_data[0]), 32'd0);
    check("rst_srt_data", 32'(srt_data[0]), 32'd0);
    check("rst_srt_en", 32'(srt_en[0]), 32'd0);
    check("rst_srt_start", 32'(srt_start[0]), 32'd0);
    check("rst_srt_pad", 32'(srt_pad[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst0", 32'(in_ready[0]), 32'd1);
    check("ready_after_rst1", 32'(in_ready[1]), 32'd1);

    // 1: back-to-back frame
    s_start = n_start[0]; s_pad = n_pad[0]; s_gap = n_gap[0];
    in_list = '{8'd5, 8'd3, 8'd7, 8'd1};
    run_frames(0, 4, -1, 0, 8'd0, 0, "t1");
    check_out("t1", 0, 8'd1, 8'd3, 8'd5, 8'd7);
    check("t1_busy_low", 32'(busy[0]), 32'd0);
    check("t1_ready_back", 32'(in_ready[0]), 32'd1);
    check("t1_valid_low", 32'(out_valid[0]), 32'd0);
    check("t1_starts", 32'(n_start[0] - s_start), 32'd1);
    check("t1_start_val", 32'(start_val[0]), 32'd5);
    check("t1_pads", 32'(n_pad[0] - s_pad), 32'd4);
    check("t1_gap", 32'(n_gap[0] - s_gap), 32'd0);

    // 2: two idle input cycles between 3 and 7
    s_gap = n_gap[0];
    in_list = '{8'd5, 8'd3, 8'd7, 8'd1};
    run_frames(0, 4, 1, 2, 8'd0, 0, "t2");
    check_out("t2", 0, 8'd1, 8'd3, 8'd5, 8'd7);
    check("t2_gap", 32'(n_gap[0] - s_gap), 32'd2);

    // 3: downstream stall while 3 is presented
    in_list = '{8'd5, 8'd3, 8'd7, 8'd1};
    run_frames(0, 4, -1, 0, 8'd3, 3, "t3");
    check_out("t3", 0, 8'd1, 8'd3, 8'd5, 8'd7);
    check("t3_busy_low", 32'(busy[0]), 32'd0);

    // 4: two frames offered continuously
    s_start = n_start[0]; s_pad = n_pad[0];
    in_list = '{8'd9, 8'd2, 8'd8, 8'd4, 8'd6, 8'd6, 8'd0, 8'd255};
    run_frames(0, 8, -1, 0, 8'd0, 0, "t4");
    check_out("t4a", 0, 8'd2, 8'd4, 8'd8, 8'd9);
    check_out("t4b", 4, 8'd0, 8'd6, 8'd6, 8'd255);
    check("t4_starts", 32'(n_start[0] - s_start), 32'd2);
    check("t4_pads", 32'(n_pad[0] - s_pad), 32'd8);

    // 5: reset after two elements accepted
    @(posedge clk);
    #1;
    check("t5_ready_idle", 32'(in_ready[0]), 32'd1);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'd11;
    @(posedge clk);
    #1;
    in_data[0]  = 8'd12;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    check("t5_busy_mid", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 32'(in_ready[0]), 32'd0);
    check("t5_rst_busy", 32'(busy[0]), 32'd0);
    check("t5_rst_srt_data", 32'(srt_data[0]), 32'd0);
    check("t5_rst_srt_en", 32'(srt_en[0]), 32'd0);
    check("t5_rst_out_valid", 32'(out_valid[0]), 32'd0);
    @(posedge clk);
    #1;
    check("t5_rst_hold_valid", 32'(out_valid[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t5_ready_rise", 32'(in_ready[0]), 32'd1);
    s_start = n_start[0];
    in_list = '{8'd4, 8'd3, 8'd2, 8'd1};
    run_frames(0, 4, -1, 0, 8'd0, 0, "t5");
    check_out("t5", 0, 8'd1, 8'd2, 8'd3, 8'd4);
    check("t5_starts", 32'(n_start[0] - s_start), 32'd1);
    check("t5_start_val", 32'(start_val[0]), 32'd4);

    // 6: SORT_LAT=1 instance
    s_pad = n_pad[1];
    in_list = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_frames(1, 4, -1, 0, 8'd0, 0, "t6a");
    check_out("t6a", 0, 8'd10, 8'd20, 8'd30, 8'd40);
    in_list = '{8'd40, 8'd30, 8'd10, 8'd20};
    run_frames(1, 4, -1, 0, 8'd0, 0, "t6b");
    check_out("t6b", 0, 8'd10, 8'd20, 8'd30, 8'd40);
    check("t6_pads", 32'(n_pad[1] - s_pad), 32'd8);
    check("t6_busy_low", 32'(busy[1]), 32'd0);

    check("badpad0", 32'(n_badpad[0]), 32'd0);
    check("badpad1", 32'(n_badpad[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
